// File: rtl/cpa_pkg.sv
// Shared constants and the stage record for the segmented carry-propagate adder pipeline.
package cpa_pkg;

    localparam int CPA_WIDTH = 8;
    localparam int CPA_SEG_W = 4;
    localparam int CPA_PW    = 2 * CPA_WIDTH;
    localparam int CPA_NSEG  = CPA_PW / CPA_SEG_W;

    // One pipeline stage: low segments already resolved in part, the rest still
    // waiting in res_sum/res_carry, and the ripple carry into the next segment.
    typedef struct packed {
        logic              valid;
        logic [CPA_PW-1:0] part;
        logic [CPA_PW-1:0] res_sum;
        logic [CPA_PW-1:0] res_carry;
        logic              carry;
    } cpa_stage_t;

endpackage

// File: rtl/cpa_seg_add.sv
// Single SEG_W-bit segment adder with carry-in and carry-out.
module cpa_seg_add #(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};

endmodule

// File: rtl/cpa_seg_pipe.sv
// Resolves a carry-save pair into a product, one SEG_W segment per pipeline stage.
// Optional out_zero/out_neg flags are built when CPA_SEG_PIPE_FLAGS_EN is defined.
module cpa_seg_pipe
    import cpa_pkg::*;
#(
    parameter int WIDTH = CPA_WIDTH,
    parameter int SEG_W = CPA_SEG_W
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] sum_in,
    input  logic [2*WIDTH-1:0] carry_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
`ifdef CPA_SEG_PIPE_FLAGS_EN
    ,
    output logic               out_zero,
    output logic               out_neg
`endif
);

    localparam int PW   = 2 * WIDTH;
    localparam int NSEG = PW / SEG_W;

    typedef struct packed {
        logic          valid;
        logic [PW-1:0] part;
        logic [PW-1:0] res_sum;
        logic [PW-1:0] res_carry;
        logic          carry;
    } stage_t;

    // Handshake: a transfer happens on a rising CLK edge when valid and ready are
    // both high. The whole pipeline freezes while the last stage holds an
    // unconsumed result, so in_ready is simply the inverse of that stall.
    logic stall;

    genvar k;
    generate
        for (k = 0; k < NSEG; k++) begin : gen_stage
            stage_t            src;
            stage_t            stage_d;
            stage_t            stage_q;
            logic [SEG_W-1:0]  seg_s;
            logic              seg_c;

            if (k == 0) begin : g_src_in
                always_comb begin
                    src           = '0;
                    src.valid     = in_valid;
                    src.res_sum   = sum_in;
                    src.res_carry = carry_in;
                end
            end else begin : g_src_prev
                assign src = gen_stage[k-1].stage_q;
            end

            cpa_seg_add #(.SEG_W(SEG_W)) u_seg_add (
                .a    (src.res_sum[k*SEG_W +: SEG_W]),
                .b    (src.res_carry[k*SEG_W +: SEG_W]),
                .cin  (src.carry),
                .s    (seg_s),
                .cout (seg_c)
            );

            always_comb begin
                stage_d = stage_q;
                if (!stall) begin
                    stage_d                        = src;
                    stage_d.part[k*SEG_W +: SEG_W] = seg_s;
                    stage_d.carry                  = seg_c;
                end
            end

            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= stage_d;
                end
            end
        end
    endgenerate

    assign out_valid = gen_stage[NSEG-1].stage_q.valid;
    assign product   = gen_stage[NSEG-1].stage_q.part;
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;

    // The top carry is dropped (result is modulo 2^PW); the last residuals are dead.
    logic unused_last;
    assign unused_last = ^{gen_stage[NSEG-1].stage_q.res_sum,
                           gen_stage[NSEG-1].stage_q.res_carry,
                           gen_stage[NSEG-1].stage_q.carry};

`ifdef CPA_SEG_PIPE_FLAGS_EN
    logic zero_d, zero_q;
    logic neg_d, neg_q;

    always_comb begin
        zero_d = zero_q;
        neg_d  = neg_q;
        if (!stall) begin
            zero_d = (gen_stage[NSEG-1].stage_d.part == '0);
            neg_d  = gen_stage[NSEG-1].stage_d.part[PW-1];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            neg_q  <= neg_d;
        end
    end

    assign out_zero = zero_q;
    assign out_neg  = neg_q;
`endif

endmodule
